fifo_unpack_gearbox: RTL and testbench

//  Downstream consumer of a depth-2 FIFO: dequeues wide words through the FIFO's
//  D_OUT/EMPTY_N/DEQ side and re-emits each one as RATIO narrow beats on a

---
 rtl/fifo_unpack_gearbox.sv | 85 ++++++++
 tb/tb_fifo_unpack_gearbox.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_unpack_gearbox.sv
// Width-down gearbox: dequeues wide words from an upstream FIFO and replays each
// one as RATIO narrow beats on a valid/ready stream, reloading without bubbles.
module fifo_unpack_gearbox #(
    parameter int unsigned in_width  = 64,
    parameter int unsigned out_width = 16,
    parameter bit          msb_first = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CLR,
    input  logic [in_width-1:0]  IN_D,
    input  logic                 IN_EMPTY_N,
    output logic                 IN_DEQ,
    output logic [out_width-1:0] OUT_D,
    output logic                 OUT_VALID,
    output logic                 OUT_LAST,
    input  logic                 OUT_READY
);

    localparam int unsigned RATIO = in_width / out_width;
    localparam int unsigned CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    if (((in_width % out_width) != 0) || (RATIO < 2)) begin : g_param_check
        $error("fifo_unpack_gearbox: in_width must be a multiple of out_width with ratio >= 2");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                              state;
    logic   [in_width-1:0]               hold_reg;
    logic   [CW-1:0]                     cnt;
    logic   [RATIO-1:0][out_width-1:0]   beats;
    logic   [CW-1:0]                     beat_idx;
    logic                                valid_reg;
    logic                                last;
    logic                                fire;
    logic                                load;

    assign valid_reg = (state == SHIFT);
    assign last      = (cnt == CW'(RATIO - 1));
    assign fire      = valid_reg && OUT_READY;

    // Reset gate keeps DEQ low while the upstream FIFO is also held in reset.
    assign load   = RST && IN_EMPTY_N && !CLR && (!valid_reg || (fire && last));
    assign IN_DEQ = load;

    // Packed view of the held word: element k is bits [k*out_width +: out_width].
    assign beats    = hold_reg;
    assign beat_idx = msb_first ? (CW'(RATIO - 1) - cnt) : cnt;

    assign OUT_D     = beats[beat_idx];
    assign OUT_VALID = valid_reg;
    assign OUT_LAST  = valid_reg && last;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            cnt      <= '0;
            hold_reg <= '0;
        end else if (CLR) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (load) begin
            hold_reg <= IN_D;
            cnt      <= '0;
            state    <= SHIFT;
        end else if (fire) begin
            if (last) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Structurally impossible; flags an edit that breaks the DEQ qualification.
    a_deq_only_when_nonempty: assert property (
        @(posedge CLK) disable iff (!RST) !(IN_DEQ && !IN_EMPTY_N)
    ) else $warning("fifo_unpack_gearbox: IN_DEQ asserted while IN_EMPTY_N=0");

endmodule

// File: tb/tb_fifo_unpack_gearbox.sv
// Directed bench for fifo_unpack_gearbox (32->8); a second instance with
// msb_first=1 shares the same stimulus.
module tb_fifo_unpack_gearbox;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic [31:0] in_d;
    logic        in_empty_n;
    logic        out_ready;

    logic        in_deq,  in_deq1;
    logic [7:0]  out_d,   out_d1;
    logic        out_valid, out_valid1;
    logic        out_last,  out_last1;

    int total = 0;
    int bad   = 0;
    logic [31:0] fifo_q[$];

    fifo_unpack_gearbox #(.in_width(32), .out_width(8), .msb_first(1'b0)) dut_lsb (
        .CLK(clk), .RST(rst_n), .CLR(clr), .IN_D(in_d), .IN_EMPTY_N(in_empty_n),
        .IN_DEQ(in_deq), .OUT_D(out_d), .OUT_VALID(out_valid), .OUT_LAST(out_last),
        .OUT_READY(out_ready)
    );

    fifo_unpack_gearbox #(.in_width(32), .out_width(8), .msb_first(1'b1)) dut_msb (
        .CLK(clk), .RST(rst_n), .CLR(clr), .IN_D(in_d), .IN_EMPTY_N(in_empty_n),
        .IN_DEQ(in_deq1), .OUT_D(out_d1), .OUT_VALID(out_valid1), .OUT_LAST(out_last1),
        .OUT_READY(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Upstream FIFO head presented to both instances.
    task automatic drive_fifo();
        in_empty_n = (fifo_q.size() != 0);
        in_d       = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    endtask

    // One clock: note DEQ before the edge, pop after it, leave time at edge+1.
    task automatic tick();
        logic d;
        #1;
        d = in_deq;
        @(posedge clk);
        #1;
        if (d && fifo_q.size() != 0) void'(fifo_q.pop_front());
        drive_fifo();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fifo_q.push_back(32'hDDCCBBAA);
        drive_fifo();
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (in_deq !== 1'b0) begin bad++; $display("FAIL reset_deq got=%b want=0", in_deq); end
        total++; if (out_d !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", out_d); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", out_last); end
        rst_n = 1'b1;
        #1;
        total++; if (in_deq !== 1'b1) begin bad++; $display("FAIL release_deq got=%b want=1", in_deq); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL release_valid got=%b want=1", out_valid); end
        total++; if (out_d !== 8'hAA) begin bad++; $display("FAIL release_beat0 got=%h want=aa", out_d); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_flush_valid got=%b want=0", out_valid); end
    endtask

    task automatic test_single();
        logic [7:0] exp [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        fifo_q.push_back(32'hDDCCBBAA);
        out_ready = 1'b1;
        drive_fifo();
        tick();
        for (int i = 0; i < 4; i++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid[%0d] got=%b want=1", i, out_valid); end
            total++; if (out_d !== exp[i]) begin bad++; $display("FAIL single_data[%0d] got=%h want=%h", i, out_d, exp[i]); end
            total++; if (out_last !== (i == 3)) begin bad++; $display("FAIL single_last[%0d] got=%b want=%b", i, out_last, (i == 3)); end
            tick();
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_idle got=%b want=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b;
        fifo_q.push_back(32'h44332211);
        fifo_q.push_back(32'h88776655);
        out_ready = 1'b1;
        drive_fifo();
        tick();
        for (int i = 0; i < 8; i++) begin
            exp_b = 8'(8'h11 * (i + 1));
            #1;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%b want=1", i, out_valid); end
            total++; if (out_d !== exp_b) begin bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", i, out_d, exp_b); end
            total++; if (in_deq !== (i == 3)) begin bad++; $display("FAIL b2b_deq[%0d] got=%b want=%b", i, in_deq, (i == 3)); end
            total++; if (out_last !== (i == 3 || i == 7)) begin bad++; $display("FAIL b2b_last[%0d] got=%b want=%b", i, out_last, (i == 3 || i == 7)); end
            tick();
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b want=0", out_valid); end
    endtask

    task automatic test_backpressure();
        fifo_q.push_back(32'hDDCCBBAA);
        out_ready = 1'b1;
        drive_fifo();
        tick();
        tick();
        fifo_q.push_back(32'h5A5A5A5A);
        drive_fifo();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (out_d !== 8'hBB) begin bad++; $display("FAIL stall_data[%0d] got=%h want=bb", i, out_d); end
            total++; if (out_valid !== 1'b1 || out_last !== 1'b0) begin bad++; $display("FAIL stall_ctl[%0d] got=%b%b want=10", i, out_valid, out_last); end
            total++; if (in_deq !== 1'b0) begin bad++; $display("FAIL stall_deq[%0d] got=%b want=0", i, in_deq); end
            tick();
        end
        total++; if (out_d !== 8'hBB) begin bad++; $display("FAIL stall_hold got=%h want=bb", out_d); end
        out_ready = 1'b1;
        tick();
        total++; if (out_d !== 8'hCC) begin bad++; $display("FAIL resume_cc got=%h want=cc", out_d); end
        tick();
        #1;
        total++; if (out_d !== 8'hDD || out_last !== 1'b1) begin bad++; $display("FAIL resume_dd got=%h/%b want=dd/1", out_d, out_last); end
        total++; if (in_deq !== 1'b1) begin bad++; $display("FAIL resume_deq got=%b want=1", in_deq); end
        tick();
        total++; if (out_d !== 8'h5A || out_valid !== 1'b1) begin bad++; $display("FAIL reload_5a got=%h/%b want=5a/1", out_d, out_valid); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_msb_first();
        logic [7:0] exp [4] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        fifo_q.push_back(32'hDDCCBBAA);
        out_ready = 1'b1;
        drive_fifo();
        tick();
        for (int i = 0; i < 4; i++) begin
            total++; if (out_d1 !== exp[i]) begin bad++; $display("FAIL msb_data[%0d] got=%h want=%h", i, out_d1, exp[i]); end
            total++; if (out_last1 !== (i == 3) || out_valid1 !== 1'b1) begin bad++; $display("FAIL msb_ctl[%0d] got=%b%b want=1%b", i, out_valid1, out_last1, (i == 3)); end
            tick();
        end
        total++; if (out_valid1 !== 1'b0) begin bad++; $display("FAIL msb_idle got=%b want=0", out_valid1); end
    endtask

    task automatic test_clr();
        logic [7:0] exp [4] = '{8'h0D, 8'h0C, 8'h0B, 8'h0A};
        fifo_q.push_back(32'hDDCCBBAA);
        fifo_q.push_back(32'h0A0B0C0D);
        out_ready = 1'b1;
        drive_fifo();
        tick();
        tick();
        tick();
        total++; if (out_d !== 8'hCC) begin bad++; $display("FAIL clr_at_cc got=%h want=cc", out_d); end
        clr = 1'b1;
        #1;
        total++; if (in_deq !== 1'b0) begin bad++; $display("FAIL clr_deq got=%b want=0", in_deq); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clr_valid got=%b want=0", out_valid); end
        total++; if (fifo_q.size() != 1) begin bad++; $display("FAIL clr_fifo_depth got=%0d want=1", fifo_q.size()); end
        clr = 1'b0;
        #1;
        total++; if (in_deq !== 1'b1) begin bad++; $display("FAIL clr_reload_deq got=%b want=1", in_deq); end
        tick();
        for (int i = 0; i < 4; i++) begin
            total++; if (out_d !== exp[i] || out_valid !== 1'b1) begin bad++; $display("FAIL clr_restart[%0d] got=%h/%b want=%h/1", i, out_d, out_valid, exp[i]); end
            tick();
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clr_idle got=%b want=0", out_valid); end
    endtask

    initial begin
        rst_n      = 1'b0;
        clr        = 1'b0;
        out_ready  = 1'b0;
        in_d       = 32'h0;
        in_empty_n = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_msb_first();
        test_clr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
